// File: rtl/vlsu_axi_txn_limiter.sv
// Outstanding-burst limiter for the vector LSU AXI master port: gates AR/AW when a bound is hit
// or a drain is requested, and reports outstanding counts and idleness for fencing.

package vlsu_axi_txn_limiter_pkg;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
  } ax_chan_t;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  strb;
    logic        last;
  } w_chan_t;

  typedef struct packed {
    logic [3:0] id;
    logic [1:0] resp;
  } b_chan_t;

  typedef struct packed {
    logic [3:0]  id;
    logic [63:0] data;
    logic [1:0]  resp;
    logic        last;
  } r_chan_t;

  typedef struct packed {
    ax_chan_t aw;
    logic     aw_valid;
    w_chan_t  w;
    logic     w_valid;
    logic     b_ready;
    ax_chan_t ar;
    logic     ar_valid;
    logic     r_ready;
  } axi_req_t;

  typedef struct packed {
    logic     aw_ready;
    logic     ar_ready;
    logic     w_ready;
    b_chan_t  b;
    logic     b_valid;
    r_chan_t  r;
    logic     r_valid;
  } axi_resp_t;

endpackage

module vlsu_axi_txn_limiter #(
  parameter int unsigned MaxRdTxn = 8,
  parameter int unsigned MaxWrTxn = 8,
  parameter type axi_req_t  = vlsu_axi_txn_limiter_pkg::axi_req_t,
  parameter type axi_resp_t = vlsu_axi_txn_limiter_pkg::axi_resp_t,
  localparam int unsigned RdCntW = $clog2(MaxRdTxn + 1),
  localparam int unsigned WrCntW = $clog2(MaxWrTxn + 1)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  axi_req_t          slv_req_i,
  output axi_resp_t         slv_resp_o,
  output axi_req_t          mst_req_o,
  input  axi_resp_t         mst_resp_i,
  input  logic              drain_i,
  output logic [RdCntW-1:0] rd_outstanding_o,
  output logic [WrCntW-1:0] wr_outstanding_o,
  output logic              idle_o,
  output logic              cnt_err_o
);

  logic [RdCntW-1:0] rd_cnt;
  logic [WrCntW-1:0] wr_cnt;
  logic              cnt_err;
  logic              rd_block;
  logic              wr_block;
  logic              rd_inc;
  logic              rd_dec;
  logic              wr_inc;
  logic              wr_dec;

  // Blocking looks only at registered counts, so R/B never reach AR/AW combinationally.
  assign rd_block = drain_i | (rd_cnt == RdCntW'(MaxRdTxn));
  assign wr_block = drain_i | (wr_cnt == WrCntW'(MaxWrTxn));

  always_comb begin
    mst_req_o           = slv_req_i;
    mst_req_o.ar_valid  = slv_req_i.ar_valid & ~rd_block;
    mst_req_o.aw_valid  = slv_req_i.aw_valid & ~wr_block;
    slv_resp_o          = mst_resp_i;
    slv_resp_o.ar_ready = mst_resp_i.ar_ready & ~rd_block;
    slv_resp_o.aw_ready = mst_resp_i.aw_ready & ~wr_block;
  end

  assign rd_inc = mst_req_o.ar_valid & mst_resp_i.ar_ready;
  assign wr_inc = mst_req_o.aw_valid & mst_resp_i.aw_ready;
  assign rd_dec = mst_resp_i.r_valid & slv_req_i.r_ready & mst_resp_i.r.last;
  assign wr_dec = mst_resp_i.b_valid & slv_req_i.b_ready;

  // A completion with nothing outstanding leaves the count at zero and latches the error.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_cnt  <= '0;
      wr_cnt  <= '0;
      cnt_err <= 1'b0;
    end else begin
      if (rd_inc && !rd_dec) begin
        rd_cnt <= rd_cnt + RdCntW'(1);
      end else if (!rd_inc && rd_dec) begin
        if (rd_cnt == '0) cnt_err <= 1'b1;
        else              rd_cnt  <= rd_cnt - RdCntW'(1);
      end
      if (wr_inc && !wr_dec) begin
        wr_cnt <= wr_cnt + WrCntW'(1);
      end else if (!wr_inc && wr_dec) begin
        if (wr_cnt == '0) cnt_err <= 1'b1;
        else              wr_cnt  <= wr_cnt - WrCntW'(1);
      end
    end
  end

  assign rd_outstanding_o = rd_cnt;
  assign wr_outstanding_o = wr_cnt;
  assign idle_o           = (rd_cnt == '0) && (wr_cnt == '0);
  assign cnt_err_o        = cnt_err;

endmodule

// File: tb/tb_vlsu_axi_txn_limiter.sv
// Bench for vlsu_axi_txn_limiter: table-driven gating vectors, directed corner sequences and a
// randomized run against a counting reference model.

module tb_vlsu_axi_txn_limiter;
  import vlsu_axi_txn_limiter_pkg::*;

  localparam int unsigned MAX_RD = 8;
  localparam int unsigned MAX_WR = 8;

  logic      clk = 1'b0;
  logic      rst;
  axi_req_t  slv_req;
  axi_resp_t slv_resp;
  axi_req_t  mst_req;
  axi_resp_t mst_resp;
  logic      drain;
  logic [3:0] rd_out;
  logic [3:0] wr_out;
  logic      idle;
  logic      err;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  always #5 clk = ~clk;

  vlsu_axi_txn_limiter #(
    .MaxRdTxn(MAX_RD),
    .MaxWrTxn(MAX_WR)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .slv_req_i       (slv_req),
    .slv_resp_o      (slv_resp),
    .mst_req_o       (mst_req),
    .mst_resp_i      (mst_resp),
    .drain_i         (drain),
    .rd_outstanding_o(rd_out),
    .wr_outstanding_o(wr_out),
    .idle_o          (idle),
    .cnt_err_o       (err)
  );

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
  endtask

  task automatic chkn(input string nm, input int unsigned act, input int unsigned exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask

  task automatic idle_in();
    slv_req  = '0;
    mst_resp = '0;
    drain    = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    idle_in();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    logic drn, arv, arr, awv, awr;
    logic e_mar, e_sar, e_maw, e_saw;
    int unsigned e_rd, e_wr;
  } vec_t;

  vec_t tbl [6];

  int unsigned m_rd, m_wr;
  logic m_err, ar_v, aw_v, rb, wb, ar_hs, aw_hs, rd_done, wr_done, rv, bv;
  logic ar_pend, aw_pend;

  initial begin
    tbl[0] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1, 0};
    tbl[1] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1, 1};
    tbl[2] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1, 1};
    tbl[3] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1, 1};
    tbl[4] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2, 1};
    tbl[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2, 1};

    idle_in();
    rst = 1'b1;
    @(negedge clk);
    chkn("reset_rd", 32'(rd_out), 0);
    chkn("reset_wr", 32'(wr_out), 0);
    chk1("reset_idle", idle, 1'b1);
    chk1("reset_err", err, 1'b0);
    chk1("reset_mst_ar_valid", mst_req.ar_valid, 1'b0);
    chk1("reset_mst_aw_valid", mst_req.aw_valid, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      drain                = tbl[i].drn;
      slv_req.ar_valid     = tbl[i].arv;
      mst_resp.ar_ready    = tbl[i].arr;
      slv_req.aw_valid     = tbl[i].awv;
      mst_resp.aw_ready    = tbl[i].awr;
      #1;
      chk1("tbl_mst_ar_valid", mst_req.ar_valid, tbl[i].e_mar);
      chk1("tbl_slv_ar_ready", slv_resp.ar_ready, tbl[i].e_sar);
      chk1("tbl_mst_aw_valid", mst_req.aw_valid, tbl[i].e_maw);
      chk1("tbl_slv_aw_ready", slv_resp.aw_ready, tbl[i].e_saw);
      tick();
      chkn("tbl_rd_cnt", 32'(rd_out), tbl[i].e_rd);
      chkn("tbl_wr_cnt", 32'(wr_out), tbl[i].e_wr);
    end

    // Read limit: 8 accepted, 9th blocked until a completion has been registered.
    do_reset();
    slv_req.ar_valid  = 1'b1;
    mst_resp.ar_ready = 1'b1;
    repeat (8) tick();
    #1;
    chkn("full_rd_cnt", 32'(rd_out), 8);
    chk1("full_slv_ar_ready", slv_resp.ar_ready, 1'b0);
    chk1("full_mst_ar_valid", mst_req.ar_valid, 1'b0);
    mst_resp.r_valid  = 1'b1;
    mst_resp.r.last   = 1'b1;
    slv_req.r_ready   = 1'b1;
    #1;
    chk1("full_same_cycle_still_blocked", mst_req.ar_valid, 1'b0);
    tick();
    mst_resp.r_valid  = 1'b0;
    slv_req.r_ready   = 1'b0;
    #1;
    chkn("full_after_r_cnt", 32'(rd_out), 7);
    chk1("full_unblock_mst_ar_valid", mst_req.ar_valid, 1'b1);
    chk1("full_unblock_slv_ar_ready", slv_resp.ar_ready, 1'b1);
    tick();
    chkn("full_9th_accepted_cnt", 32'(rd_out), 8);

    // Simultaneous AW and B handshake leaves the write count unchanged.
    do_reset();
    slv_req.aw_valid  = 1'b1;
    mst_resp.aw_ready = 1'b1;
    repeat (3) tick();
    chkn("aw3_cnt", 32'(wr_out), 3);
    mst_resp.b_valid  = 1'b1;
    slv_req.b_ready   = 1'b1;
    #1;
    chk1("b_passthrough", slv_resp.b_valid, 1'b1);
    tick();
    idle_in();
    chkn("aw_b_same_cycle_cnt", 32'(wr_out), 3);
    chk1("aw_b_same_cycle_idle", idle, 1'b0);

    // Drain with 2 reads and 1 write outstanding.
    do_reset();
    slv_req.ar_valid  = 1'b1;
    mst_resp.ar_ready = 1'b1;
    slv_req.aw_valid  = 1'b1;
    mst_resp.aw_ready = 1'b1;
    tick();
    slv_req.aw_valid  = 1'b0;
    tick();
    slv_req.ar_valid  = 1'b0;
    drain = 1'b1;
    tick();
    slv_req.ar_valid  = 1'b1;
    slv_req.aw_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk1("drain_mst_ar_valid", mst_req.ar_valid, 1'b0);
      chk1("drain_mst_aw_valid", mst_req.aw_valid, 1'b0);
      tick();
    end
    chkn("drain_rd_cnt", 32'(rd_out), 2);
    chkn("drain_wr_cnt", 32'(wr_out), 1);
    mst_resp.r_valid = 1'b1;
    mst_resp.r.last  = 1'b1;
    slv_req.r_ready  = 1'b1;
    mst_resp.b_valid = 1'b1;
    slv_req.b_ready  = 1'b1;
    tick();
    mst_resp.b_valid = 1'b0;
    chkn("drain_rd_after1", 32'(rd_out), 1);
    chkn("drain_wr_after1", 32'(wr_out), 0);
    #1;
    chk1("drain_idle_during_last", idle, 1'b0);
    tick();
    mst_resp.r_valid = 1'b0;
    chk1("drain_idle_after_last", idle, 1'b1);
    chkn("drain_rd_zero", 32'(rd_out), 0);

    // Multi-beat read: only the last beat completes the burst.
    do_reset();
    slv_req.ar_valid  = 1'b1;
    slv_req.ar.len    = 8'd3;
    mst_resp.ar_ready = 1'b1;
    tick();
    slv_req.ar_valid  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      mst_resp.r_valid = 1'b1;
      slv_req.r_ready  = 1'b1;
      mst_resp.r.last  = (i == 3);
      tick();
      chkn("burst_beat_cnt", 32'(rd_out), (i == 3) ? 0 : 1);
    end
    idle_in();

    // B with nothing outstanding latches the error until reset.
    do_reset();
    mst_resp.b_valid = 1'b1;
    slv_req.b_ready  = 1'b1;
    tick();
    idle_in();
    chk1("underflow_err", err, 1'b1);
    chkn("underflow_wr_cnt", 32'(wr_out), 0);
    repeat (3) tick();
    chk1("underflow_err_sticky", err, 1'b1);
    do_reset();
    chk1("underflow_err_cleared", err, 1'b0);

    // Randomized traffic against the counting model.
    do_reset();
    m_rd = 0; m_wr = 0; m_err = 1'b0;
    ar_v = 1'b0; aw_v = 1'b0; ar_pend = 1'b0; aw_pend = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      if (!ar_v && !aw_v && $urandom_range(0, 7) == 0) drain = ~drain;
      if (!ar_v && !drain) begin
        ar_v = 1'($urandom_range(0, 1));
        slv_req.ar.addr = 32'($urandom());
        slv_req.ar.len  = 8'($urandom_range(0, 15));
      end
      if (!aw_v && !drain) begin
        aw_v = 1'($urandom_range(0, 1));
        slv_req.aw.addr = 32'($urandom());
      end
      slv_req.ar_valid  = ar_v;
      slv_req.aw_valid  = aw_v;
      mst_resp.ar_ready = 1'($urandom_range(0, 1));
      mst_resp.aw_ready = 1'($urandom_range(0, 1));
      rv = (m_rd > 0) && ($urandom_range(0, 1) == 1);
      bv = (m_wr > 0) && ($urandom_range(0, 1) == 1);
      mst_resp.r_valid  = rv;
      mst_resp.r.last   = 1'($urandom_range(0, 1));
      slv_req.r_ready   = 1'($urandom_range(0, 1));
      mst_resp.b_valid  = bv;
      slv_req.b_ready   = 1'($urandom_range(0, 1));
      slv_req.w_valid   = 1'($urandom_range(0, 1));
      mst_resp.w_ready  = 1'($urandom_range(0, 1));
      #1;
      rb = drain || (m_rd == MAX_RD);
      wb = drain || (m_wr == MAX_WR);
      chk1("rnd_mst_ar_valid", mst_req.ar_valid, ar_v && !rb);
      chk1("rnd_slv_ar_ready", slv_resp.ar_ready, mst_resp.ar_ready && !rb);
      chk1("rnd_mst_aw_valid", mst_req.aw_valid, aw_v && !wb);
      chk1("rnd_slv_aw_ready", slv_resp.aw_ready, mst_resp.aw_ready && !wb);
      chkn("rnd_rd_cnt", 32'(rd_out), m_rd);
      chkn("rnd_wr_cnt", 32'(wr_out), m_wr);
      chk1("rnd_idle", idle, (m_rd == 0) && (m_wr == 0));
      chk1("rnd_err", err, m_err);
      chk1("rnd_w_valid_pass", mst_req.w_valid, slv_req.w_valid);
      chk1("rnd_r_valid_pass", slv_resp.r_valid, rv);
      chkn("rnd_ar_addr_pass", mst_req.ar.addr, slv_req.ar.addr);
      if (ar_pend) chk1("rnd_ar_valid_stable", mst_req.ar_valid, 1'b1);
      if (aw_pend) chk1("rnd_aw_valid_stable", mst_req.aw_valid, 1'b1);
      ar_pend = mst_req.ar_valid && !mst_resp.ar_ready;
      aw_pend = mst_req.aw_valid && !mst_resp.aw_ready;
      ar_hs   = ar_v && mst_resp.ar_ready && !rb;
      aw_hs   = aw_v && mst_resp.aw_ready && !wb;
      rd_done = rv && slv_req.r_ready && mst_resp.r.last;
      wr_done = bv && slv_req.b_ready;
      @(posedge clk);
      if (ar_hs && !rd_done) m_rd++;
      else if (!ar_hs && rd_done) begin
        if (m_rd == 0) m_err = 1'b1; else m_rd--;
      end
      if (aw_hs && !wr_done) m_wr++;
      else if (!aw_hs && wr_done) begin
        if (m_wr == 0) m_err = 1'b1; else m_wr--;
      end
      if (ar_hs) ar_v = 1'b0;
      if (aw_hs) aw_v = 1'b0;
      @(negedge clk);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
